// File: rtl/keylock_pkg.sv
// Shared types and the key-gate function for the key-gated pipeline lock.
package keylock_pkg;

    // Lock controller states: no key, key being shifted in, key held.
    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        LOAD   = 2'd1,
        ARMED  = 2'd2
    } lock_state_e;

    // Widest data word gate_apply can handle; callers zero-extend into it.
    localparam int GATE_MAX_W = 64;

    // Bit i of the result is data[i] ^ key[i % key_w] ^ pol[i % key_w].
    // A pol bit of 1 turns that key bit's XOR gate into an XNOR gate.
    function automatic logic [GATE_MAX_W-1:0] gate_apply(
        input logic [GATE_MAX_W-1:0] data,
        input logic [GATE_MAX_W-1:0] key,
        input logic [GATE_MAX_W-1:0] pol,
        input int                    key_w
    );
        logic [GATE_MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < GATE_MAX_W; i++) begin
            res[i] = data[i] ^ key[i % key_w] ^ pol[i % key_w];
        end
        return res;
    endfunction

endpackage

// File: rtl/keygate_pipe_lock_if.sv
// Key-load port and data stream handshakes of the key-gated pipeline lock.
interface keygate_pipe_lock_if #(
    parameter int DATA_W = 32,
    parameter int LOAD_W = 1
);
    logic              key_start;
    logic              key_valid;
    logic              key_ready;
    logic [LOAD_W-1:0] key_data;
    logic              key_armed;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Source / consumer side.
    modport master (
        output key_start, key_valid, key_data, in_valid, in_data, out_ready,
        input  key_ready, key_armed, in_ready, out_valid, out_data
    );

    // Lock block side.
    modport slave (
        input  key_start, key_valid, key_data, in_valid, in_data, out_ready,
        output key_ready, key_armed, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/keylock_pipe_stage.sv
// One elastic register slot: takes a new word whenever it is empty or its
// word is being taken downstream in the same cycle, so bubbles collapse.
module keylock_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next slot contents: load on advance, otherwise hold (data stays steady).
    always_comb begin
        // NOTE: defaults assigned first so every path drives every output; no latch inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops sample pre-edge values together.
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/keygate_pipe_lock.sv
// Key-gated pipeline lock: shifts a key in over a valid/ready port, then
// streams data through an XOR/XNOR gate stage followed by plain register stages.
module keygate_pipe_lock
    import keylock_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               KEY_W   = 32,
    parameter int               LOAD_W  = 1,
    parameter logic [KEY_W-1:0] KEY_POL = '0,
    parameter int               STAGES  = 2
) (
    input logic               clk,
    input logic               rst,
    keygate_pipe_lock_if.slave bus
);
    localparam int                    BEATS     = KEY_W / LOAD_W;
    localparam int                    CNT_W     = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [GATE_MAX_W-1:0] POL_EXT   = GATE_MAX_W'(KEY_POL);

    lock_state_e      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_ready_q, key_ready_d;
    logic             key_armed_q, key_armed_d;

    // Stage chain: index 0 is the gated input, index STAGES the output.
    logic [STAGES:0]  stg_valid;
    logic [STAGES:0]  stg_ready;
    logic [DATA_W-1:0] stg_data [STAGES+1];
    logic             pipe_empty;

    assign pipe_empty = (stg_valid[STAGES:1] == '0);

    // Lock FSM and key shifter next-state; key_start wins over a same-cycle beat.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOCKED: begin
                if (bus.key_start) begin
                    state_d = LOAD;
                    key_d   = '0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (bus.key_start) begin
                    key_d = '0;
                    cnt_d = '0;
                end else if (bus.key_valid) begin
                    key_d = (key_q << LOAD_W) | KEY_W'(bus.key_data);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ARMED: begin
                // Re-keying only on a drained pipeline; otherwise the caller retries.
                if (bus.key_start && pipe_empty) begin
                    state_d = LOAD;
                    key_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = LOCKED;
        endcase
        key_ready_d = (state_d == LOAD);
        key_armed_d = (state_d == ARMED);
    end

    // Lock state, key, beat counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOCKED;
            key_q       <= '0;
            cnt_q       <= '0;
            key_ready_q <= 1'b0;
            key_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            key_ready_q <= key_ready_d;
            key_armed_q <= key_armed_d;
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.key_armed = key_armed_q;

    // Gate is applied on the way into stage 1 using the held key.
    assign stg_valid[0] = bus.in_valid && key_armed_q;
    assign stg_data[0]  = DATA_W'(gate_apply(GATE_MAX_W'(bus.in_data),
                                             GATE_MAX_W'(key_q), POL_EXT, KEY_W));
    // Masked during reset so no handshake completes in the reset cycle.
    assign bus.in_ready = key_armed_q && stg_ready[0] && !rst;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        keylock_pipe_stage #(.W(DATA_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (stg_valid[s]),
            .in_ready  (stg_ready[s]),
            .in_data   (stg_data[s]),
            .out_valid (stg_valid[s+1]),
            .out_ready (stg_ready[s+1]),
            .out_data  (stg_data[s+1])
        );
    end

    assign stg_ready[STAGES] = bus.out_ready;
    assign bus.out_valid     = stg_valid[STAGES] && !rst;
    assign bus.out_data      = stg_data[STAGES];
endmodule

// File: tb/tb_keygate_pipe_lock.sv
// Directed bench: dut0 uses KEY_POL=0, dut1 KEY_POL=FFFF_0000. dut1 shares
// every handshake with dut0 but always receives zero key beats.
module tb_keygate_pipe_lock;
    import keylock_pkg::*;

    localparam logic [31:0] KEY_A = 32'hA5A5_0F0F;
    localparam logic [31:0] KEY_B = 32'h3C3C_C3C3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rxq [$];

    always #5 clk = ~clk;

    keygate_pipe_lock_if #(.DATA_W(32), .LOAD_W(1)) bus0 ();
    keygate_pipe_lock_if #(.DATA_W(32), .LOAD_W(1)) bus1 ();

    assign bus1.key_start = bus0.key_start;
    assign bus1.key_valid = bus0.key_valid;
    assign bus1.key_data  = 1'b0;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_data   = bus0.in_data;
    assign bus1.out_ready = bus0.out_ready;

    keygate_pipe_lock #(.DATA_W(32), .KEY_W(32), .LOAD_W(1),
                        .KEY_POL(32'h0), .STAGES(2)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave));

    keygate_pipe_lock #(.DATA_W(32), .KEY_W(32), .LOAD_W(1),
                        .KEY_POL(32'hFFFF_0000), .STAGES(2)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave));

    // Output scoreboard capture: inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && bus0.out_ready) rxq.push_back(bus0.out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus0.key_start = 1'b0;
        bus0.key_valid = 1'b0;
        bus0.key_data  = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.out_ready = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        bus0.key_start = 1'b1;
        step();
        bus0.key_start = 1'b0;
        #1;
        checks++;
        if ({bus0.key_ready, bus0.key_armed} !== 2'b10) begin
            errors++;
            $display("FAIL load_enter got ready/armed %b exp 10", {bus0.key_ready, bus0.key_armed});
        end
        for (int b = 0; b < 32; b++) begin
            bus0.key_valid = 1'b1;
            bus0.key_data  = k[31-b];
            if (b == 31) begin
                #1;
                checks++;
                if (bus0.key_armed !== 1'b0) begin
                    errors++;
                    $display("FAIL armed_early got %b exp 0", bus0.key_armed);
                end
            end
            step();
        end
        bus0.key_valid = 1'b0;
        #1;
        checks++;
        if ({bus0.key_ready, bus0.key_armed} !== 2'b01) begin
            errors++;
            $display("FAIL armed_after_last got ready/armed %b exp 01", {bus0.key_ready, bus0.key_armed});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bus0.key_start = 1'($urandom);
            bus0.key_valid = 1'($urandom);
            bus0.key_data  = 1'($urandom);
            bus0.in_valid  = 1'($urandom);
            bus0.in_data   = $urandom;
            bus0.out_ready = 1'($urandom);
            step();
            #1;
            checks++;
            if ({bus0.key_ready, bus0.key_armed, bus0.in_ready, bus0.out_valid, bus0.out_data} !== 36'd0) begin
                errors++;
                $display("FAIL reset_outputs got %h exp 0",
                         {bus0.key_ready, bus0.key_armed, bus0.in_ready, bus0.out_valid, bus0.out_data});
            end
        end
        clear_inputs();
        rst = 1'b0;
        bus0.in_valid = 1'b1;
        step();
        #1;
        checks++;
        if ({bus0.in_ready, bus0.key_armed, bus0.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL locked_in_ready got %b exp 000", {bus0.in_ready, bus0.key_armed, bus0.out_valid});
        end
        bus0.in_valid = 1'b0;
    endtask

    task automatic test_key_load();
        rxq.delete();
        load_key(KEY_A);
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 32'h0;
        bus0.out_ready = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        #1;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got %b exp 0", bus0.out_valid);
        end
        step();
        #1;
        checks++;
        if ({bus0.out_valid, bus0.out_data} !== {1'b1, KEY_A}) begin
            errors++;
            $display("FAIL zero_word got %b/%h exp 1/%h", bus0.out_valid, bus0.out_data, KEY_A);
        end
        checks++;
        if ({bus1.out_valid, bus1.out_data} !== {1'b1, 32'hFFFF_0000}) begin
            errors++;
            $display("FAIL zero_word_pol got %b/%h exp 1/ffff0000", bus1.out_valid, bus1.out_data);
        end
        step();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_polarity();
        logic [GATE_MAX_W-1:0] fn;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 32'h1234_5678;
        bus0.out_ready = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        step();
        #1;
        checks++;
        if ({bus1.out_valid, bus1.out_data} !== {1'b1, 32'hEDCB_5678}) begin
            errors++;
            $display("FAIL xnor_pol got %b/%h exp 1/edcb5678", bus1.out_valid, bus1.out_data);
        end
        checks++;
        if (bus0.out_data !== 32'hB791_5977) begin
            errors++;
            $display("FAIL xor_key got %h exp b7915977", bus0.out_data);
        end
        fn = gate_apply(64'h1234_5678, 64'h0, 64'hFFFF_0000, 32);
        checks++;
        if (fn[31:0] !== 32'hEDCB_5678) begin
            errors++;
            $display("FAIL gate_apply_fn got %h exp edcb5678", fn[31:0]);
        end
        step();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        rxq.delete();
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 32'h100 + 32'(i);
            @(negedge clk);
            if (bus0.in_ready !== 1'b1) stalls++;
            step();
        end
        bus0.in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (stalls != 0 || rxq.size() != 8) begin
            errors++;
            $display("FAIL b2b_throughput got stalls %0d words %0d exp 0 / 8", stalls, rxq.size());
        end
        for (int i = 0; i < 8 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== ((32'h100 + 32'(i)) ^ KEY_A)) begin
                errors++;
                $display("FAIL b2b_word%0d got %h exp %h", i, rxq[i], (32'h100 + 32'(i)) ^ KEY_A);
            end
        end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int          idx = 0;
        int          cyc = 0;
        int          bad_ready = 0;
        logic [31:0] held = '0;
        rxq.delete();
        while (idx < 10 && cyc < 100) begin
            bus0.in_valid  = 1'b1;
            bus0.in_data   = 32'(idx);
            bus0.out_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (bus0.in_ready) idx++;
            step();
            cyc++;
        end
        bus0.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 32'(idx);
            @(negedge clk);
            if (bus0.in_ready) idx++;
            if (c == 2) held = bus0.out_data;
            if (c >= 2 && bus0.in_ready !== 1'b0) bad_ready++;
            step();
        end
        #1;
        checks++;
        if (bad_ready != 0 || bus0.out_valid !== 1'b1 || bus0.out_data !== held) begin
            errors++;
            $display("FAIL full_stall got ready_hits %0d valid %b data %h exp 0 / 1 / %h",
                     bad_ready, bus0.out_valid, bus0.out_data, held);
        end
        bus0.out_ready = 1'b1;
        while (idx < 16 && cyc < 300) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 32'(idx);
            @(negedge clk);
            if (bus0.in_ready) idx++;
            step();
            cyc++;
        end
        bus0.in_valid = 1'b0;
        while (rxq.size() < 16 && cyc < 400) begin
            step();
            cyc++;
        end
        repeat (3) step();
        checks++;
        if (rxq.size() != 16) begin
            errors++;
            $display("FAIL bp_count got %0d exp 16", rxq.size());
        end
        for (int i = 0; i < 16 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== (32'(i) ^ KEY_A)) begin
                errors++;
                $display("FAIL bp_word%0d got %h exp %h", i, rxq[i], 32'(i) ^ KEY_A);
            end
        end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_rekey();
        rxq.delete();
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 32'h55;
        step();
        bus0.in_data   = 32'hAA;
        step();
        bus0.in_valid  = 1'b0;
        bus0.key_start = 1'b1;
        step();
        bus0.key_start = 1'b0;
        #1;
        checks++;
        if ({bus0.key_ready, bus0.key_armed} !== 2'b01) begin
            errors++;
            $display("FAIL rekey_busy got ready/armed %b exp 01", {bus0.key_ready, bus0.key_armed});
        end
        bus0.out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (rxq.size() != 2 || rxq[0] !== (32'h55 ^ KEY_A) || rxq[1] !== (32'hAA ^ KEY_A)) begin
            errors++;
            $display("FAIL rekey_drain got %0d words first %h exp 2 words %h %h",
                     rxq.size(), (rxq.size() > 0) ? rxq[0] : 32'h0, 32'h55 ^ KEY_A, 32'hAA ^ KEY_A);
        end
        bus0.key_start = 1'b1;
        step();
        bus0.key_start = 1'b0;
        bus0.in_valid  = 1'b1;
        #1;
        checks++;
        if ({bus0.key_ready, bus0.key_armed, bus0.in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL rekey_empty got ready/armed/in_ready %b exp 100",
                     {bus0.key_ready, bus0.key_armed, bus0.in_ready});
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_midload_reset();
        for (int b = 0; b < 10; b++) begin
            bus0.key_valid = 1'b1;
            bus0.key_data  = KEY_B[31-b];
            step();
        end
        bus0.key_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus0.key_ready, bus0.key_armed} !== 2'b00 || dut0.key_q !== 32'h0 || dut0.state_q !== LOCKED) begin
            errors++;
            $display("FAIL midload_reset got ready/armed %b key %h state %0d exp 00 / 0 / LOCKED",
                     {bus0.key_ready, bus0.key_armed}, dut0.key_q, dut0.state_q);
        end
        load_key(KEY_B);
        rxq.delete();
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 32'hFFFF_FFFF;
        bus0.out_ready = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        step();
        #1;
        checks++;
        if ({bus0.out_valid, bus0.out_data} !== {1'b1, 32'hC3C3_3C3C}) begin
            errors++;
            $display("FAIL reload_word got %b/%h exp 1/c3c33c3c", bus0.out_valid, bus0.out_data);
        end
        checks++;
        if (bus1.out_data !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL reload_pol got %h exp 0000ffff", bus1.out_data);
        end
        step();
        bus0.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_key_load();
        test_polarity();
        test_back_to_back();
        test_backpressure();
        test_rekey();
        test_midload_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
